// File: rtl/fp_check_scoreboard.sv
// In-order result scoreboard for the floating-point unit.
// Expected {result, flags, fmt} entries are queued in a FIFO; each DUT
// completion is compared against the oldest queued entry. Pass/fail counts
// and the first failing record are kept.
// Optional feature macro: FP_CHECK_NAN_MASK_EN enables canonical-NaN masking
// of the result compare (flags are always compared exactly).
module fp_check_scoreboard #(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 32,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [63:0]                exp_result,
  input  logic [4:0]                 exp_flags,
  input  logic [1:0]                 exp_fmt,
  input  logic                       res_valid,
  input  logic [63:0]                res_result,
  input  logic [4:0]                 res_flags,
  output logic [$clog2(DEPTH):0]     pending,
  output logic [CNT_W-1:0]           pass_count,
  output logic [CNT_W-1:0]           fail_count,
  output logic                       fail,
  output logic                       halted,
  output logic                       underflow,
  output logic [63:0]                cap_exp,
  output logic [63:0]                cap_calc,
  output logic [4:0]                 cap_flags_exp,
  output logic [4:0]                 cap_flags_calc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pending_q;
  logic            exp_ready_q, exp_ready_d;
  logic [CNT_W-1:0] pass_q, fail_cnt_q;
  logic            fail_q, underflow_q;
  logic [63:0]     cap_exp_q, cap_calc_q;
  logic [4:0]      cap_fe_q, cap_fc_q;

  logic [63:0]     mem_res [DEPTH];
  logic [4:0]      mem_flg [DEPTH];

  logic            run, empty, push, pop, under, match, miss, full_d;
  logic [63:0]     head_res, rdiff, mask;
  logic [4:0]      head_flg, fdiff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign run      = (state_q == RUN);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = exp_valid & exp_ready_q;
  assign pop      = res_valid & run & ~empty;
  assign under    = res_valid & run & empty;
  assign head_res = mem_res[rd_ptr_q[AW-1:0]];
  assign head_flg = mem_flg[rd_ptr_q[AW-1:0]];
  assign rdiff    = head_res ^ res_result;
  assign fdiff    = head_flg ^ res_flags;
  assign match    = ((rdiff & ~mask) == 64'd0) && (fdiff == 5'd0);
  assign miss     = pop & ~match;

`ifdef FP_CHECK_NAN_MASK_EN
  logic [1:0] mem_fmt [DEPTH];
  logic [1:0] head_fmt;
  assign head_fmt = mem_fmt[rd_ptr_q[AW-1:0]];

  // Canonical-NaN masking: only sign/payload bits outside the quiet NaN are ignored
  always_comb begin
    mask = '0;
    if (head_fmt == 2'd0 && res_result == 64'h0000_0000_7FC0_0000) begin
      mask[21:0]  = '1;
      mask[63:31] = '1;
    end else if (head_fmt == 2'd1 && res_result == 64'h7FF8_0000_0000_0000) begin
      mask[50:0] = '1;
      mask[63]   = 1'b1;
    end
  end

  // Format tag storage alongside the queued entries
  always_ff @(posedge clock) begin
    if (push) mem_fmt[wr_ptr_q[AW-1:0]] <= exp_fmt;
  end
`else
  logic unused_fmt;
  assign unused_fmt = ^exp_fmt;
  assign mask = '0;
`endif

  // Expected-entry storage; data path carries no reset
  always_ff @(posedge clock) begin
    if (push) begin
      mem_res[wr_ptr_q[AW-1:0]] <= exp_result;
      mem_flg[wr_ptr_q[AW-1:0]] <= exp_flags;
    end
  end

  // Next state: halt on underflow, or on mismatch when stopping is enabled
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:  if (under || (miss && STOP_ON_FAIL != 0)) state_d = HALT;
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Pointer advance and registered ready; full when MSBs differ and low bits match
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    full_d      = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    exp_ready_d = (state_d == RUN) && !full_d;
  end

  // Control, statistics and first-failure capture
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pending_q   <= '0;
      exp_ready_q <= 1'b1;
      pass_q      <= '0;
      fail_cnt_q  <= '0;
      fail_q      <= 1'b0;
      underflow_q <= 1'b0;
      cap_exp_q   <= '0;
      cap_calc_q  <= '0;
      cap_fe_q    <= '0;
      cap_fc_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_q   <= wr_ptr_d - rd_ptr_d;
      exp_ready_q <= exp_ready_d;
      fail_q      <= miss;
      if (under) underflow_q <= 1'b1;
      if (pop && match) pass_q <= sat_inc(pass_q);
      if (miss) begin
        fail_cnt_q <= sat_inc(fail_cnt_q);
        if (fail_cnt_q == '0) begin
          cap_exp_q  <= head_res;
          cap_calc_q <= res_result;
          cap_fe_q   <= head_flg;
          cap_fc_q   <= res_flags;
        end
      end
    end
  end

  assign exp_ready      = exp_ready_q;
  assign pending        = pending_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_cnt_q;
  assign fail           = fail_q;
  assign halted         = (state_q == HALT);
  assign underflow      = underflow_q;
  assign cap_exp        = cap_exp_q;
  assign cap_calc       = cap_calc_q;
  assign cap_flags_exp  = cap_fe_q;
  assign cap_flags_calc = cap_fc_q;

endmodule

// File: tb/tb_fp_check_scoreboard.sv
// Self-checking bench for fp_check_scoreboard. Instance A stops on first
// failure, instance B keeps checking; both see the same stimulus.
module tb_fp_check_scoreboard;

  localparam int DEPTH = 8;
  localparam int PW    = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, clear, exp_valid, res_valid;
  logic [63:0] exp_result, res_result;
  logic [4:0]  exp_flags, res_flags;
  logic [1:0]  exp_fmt;

  logic          a_rdy, a_fail, a_halt, a_und, b_rdy, b_fail, b_halt, b_und;
  logic [PW-1:0] a_pend, b_pend;
  logic [31:0]   a_pass, a_fcnt, b_pass, b_fcnt;
  logic [63:0]   a_cexp, a_ccalc, b_cexp, b_ccalc;
  logic [4:0]    a_cfe, a_cfc, b_cfe, b_cfc;

  fp_check_scoreboard #(.DEPTH(DEPTH), .CNT_W(32), .STOP_ON_FAIL(1)) dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(a_rdy), .exp_result(exp_result),
    .exp_flags(exp_flags), .exp_fmt(exp_fmt),
    .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags),
    .pending(a_pend), .pass_count(a_pass), .fail_count(a_fcnt), .fail(a_fail),
    .halted(a_halt), .underflow(a_und), .cap_exp(a_cexp), .cap_calc(a_ccalc),
    .cap_flags_exp(a_cfe), .cap_flags_calc(a_cfc));

  fp_check_scoreboard #(.DEPTH(DEPTH), .CNT_W(32), .STOP_ON_FAIL(0)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(b_rdy), .exp_result(exp_result),
    .exp_flags(exp_flags), .exp_fmt(exp_fmt),
    .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags),
    .pending(b_pend), .pass_count(b_pass), .fail_count(b_fcnt), .fail(b_fail),
    .halted(b_halt), .underflow(b_und), .cap_exp(b_cexp), .cap_calc(b_ccalc),
    .cap_flags_exp(b_cfe), .cap_flags_calc(b_cfc));

  typedef struct {
    logic [63:0] r;
    logic [4:0]  f;
    logic [1:0]  fmt;
  } ent_t;

  // Scoreboard model of instance A (STOP_ON_FAIL=1)
  ent_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_pass, m_fail;
  bit          m_failp, m_halt, m_under;
  logic [63:0] m_cexp, m_ccalc;
  logic [4:0]  m_cfe, m_cfc;

  function automatic bit model_match(input ent_t e, input logic [63:0] cr, input logic [4:0] cf);
    logic [63:0] d;
    d = e.r ^ cr;
`ifdef FP_CHECK_NAN_MASK_EN
    if (e.fmt == 2'd0 && cr == 64'h0000_0000_7FC0_0000) begin
      d[21:0] = '0; d[63:31] = '0;
    end else if (e.fmt == 2'd1 && cr == 64'h7FF8_0000_0000_0000) begin
      d[50:0] = '0; d[63] = 1'b0;
    end
`endif
    return (d == 64'd0) && (e.f == cf);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pass = 0; m_fail = 0; m_failp = 0; m_halt = 0; m_under = 0;
    m_cexp = '0; m_ccalc = '0; m_cfe = '0; m_cfc = '0;
  endtask

  // One clock of stimulus; expected entries queued on push, popped on completion
  task automatic drive_cycle(input bit pe, input logic [63:0] r, input logic [4:0] f,
                             input logic [1:0] fmt, input bit ve,
                             input logic [63:0] cr, input logic [4:0] cf);
    bit   pok;
    ent_t e;
    exp_valid = pe; exp_result = r; exp_flags = f; exp_fmt = fmt;
    res_valid = ve; res_result = cr; res_flags = cf;
    @(posedge clock);
    pok = pe && !m_halt && (q.size() < DEPTH);
    m_failp = 0;
    if (ve && !m_halt) begin
      if (q.size() == 0) begin
        m_under = 1; m_halt = 1;
      end else begin
        e = q.pop_front();
        if (model_match(e, cr, cf)) m_pass++;
        else begin
          if (m_fail == 0) begin
            m_cexp = e.r; m_ccalc = cr; m_cfe = e.f; m_cfc = cf;
          end
          m_fail++; m_failp = 1; m_halt = 1;
        end
      end
    end
    if (pok) begin
      e.r = r; e.f = f; e.fmt = fmt;
      q.push_back(e);
    end
    #1;
    exp_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock);
    model_reset();
    #1 clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    @(posedge clock); #1;
    n_checks++; if (a_pend !== 4'd0) begin n_errors++; $display("FAIL rst_pending: got %0d want 0", a_pend); end
    n_checks++; if (a_rdy !== 1'b1) begin n_errors++; $display("FAIL rst_exp_ready: got %b want 1", a_rdy); end
    n_checks++; if (a_pass !== 32'd0 || a_fcnt !== 32'd0) begin n_errors++; $display("FAIL rst_counts: got %0d/%0d want 0/0", a_pass, a_fcnt); end
    n_checks++; if ({a_fail, a_halt, a_und} !== 3'b000) begin n_errors++; $display("FAIL rst_status: got %b want 000", {a_fail, a_halt, a_und}); end
    n_checks++; if ({a_cexp, a_ccalc, a_cfe, a_cfc} !== '0) begin n_errors++; $display("FAIL rst_capture: got %h/%h want 0", a_cexp, a_ccalc); end
  endtask

  task automatic test_basic();
    do_clear();
    for (int i = 0; i < 3; i++) drive_cycle(1, 64'h3F80_0000, 5'd0, 2'd0, 0, 64'd0, 5'd0);
    n_checks++; if (a_pend !== 4'd3) begin n_errors++; $display("FAIL basic_fill: got %0d want 3", a_pend); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 64'd0, 5'd0, 2'd0, 1, 64'h3F80_0000, 5'd0);
      n_checks++; if (a_fail !== 1'b0) begin n_errors++; $display("FAIL basic_fail_pulse: got %b want 0", a_fail); end
    end
    n_checks++; if (a_pass !== 32'd3 || a_pass !== 32'(m_pass)) begin n_errors++; $display("FAIL basic_pass: got %0d want 3", a_pass); end
    n_checks++; if (a_pend !== 4'd0) begin n_errors++; $display("FAIL basic_drain: got %0d want 0", a_pend); end
  endtask

  task automatic test_full();
    ent_t h;
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++)
      drive_cycle(1, 64'h1000 + 64'(i), 5'(i), 2'd1, 0, 64'd0, 5'd0);
    n_checks++; if (a_pend !== 4'd8) begin n_errors++; $display("FAIL full_pending: got %0d want 8", a_pend); end
    n_checks++; if (a_rdy !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b want 0", a_rdy); end
    h = q[0];
    drive_cycle(1, 64'hDEAD, 5'd3, 2'd1, 1, h.r, h.f);
    n_checks++; if (a_pend !== 4'd7 || q.size() != 7) begin n_errors++; $display("FAIL full_pop_push: got %0d want 7", a_pend); end
    n_checks++; if (a_rdy !== 1'b1) begin n_errors++; $display("FAIL full_ready_again: got %b want 1", a_rdy); end
    while (q.size() > 0) begin
      h = q[0];
      drive_cycle(0, 64'd0, 5'd0, 2'd0, 1, h.r, h.f);
    end
    n_checks++; if (a_pass !== 32'd8 || a_fcnt !== 32'd0) begin n_errors++; $display("FAIL full_b2b_pass: got %0d/%0d want 8/0", a_pass, a_fcnt); end
  endtask

  task automatic test_nan();
    do_clear();
    drive_cycle(1, 64'h7FC0_0001, 5'd0, 2'd0, 0, 64'd0, 5'd0);
    drive_cycle(0, 64'd0, 5'd0, 2'd0, 1, 64'h7FC0_0000, 5'd0);
    n_checks++; if (a_fail !== m_failp) begin n_errors++; $display("FAIL nan_fail_pulse: got %b want %b", a_fail, m_failp); end
    n_checks++; if (a_pass !== 32'(m_pass) || a_fcnt !== 32'(m_fail)) begin n_errors++; $display("FAIL nan_counts: got %0d/%0d want %0d/%0d", a_pass, a_fcnt, m_pass, m_fail); end
`ifdef FP_CHECK_NAN_MASK_EN
    n_checks++; if (a_pass !== 32'd1) begin n_errors++; $display("FAIL nan_masked_pass: got %0d want 1", a_pass); end
`else
    n_checks++; if (a_ccalc !== 64'h7FC0_0000) begin n_errors++; $display("FAIL nan_cap_calc: got %h want 7fc00000", a_ccalc); end
`endif
  endtask

  task automatic test_flags_halt();
    do_clear();
    drive_cycle(1, 64'h3F80_0000, 5'h01, 2'd0, 0, 64'd0, 5'd0);
    drive_cycle(1, 64'h4000_0000, 5'h00, 2'd0, 1, 64'h3F80_0000, 5'h00);
    n_checks++; if (a_fcnt !== 32'd1 || a_fail !== 1'b1) begin n_errors++; $display("FAIL flags_fail: got cnt %0d pulse %b want 1/1", a_fcnt, a_fail); end
    n_checks++; if (a_halt !== 1'b1 || a_rdy !== 1'b0) begin n_errors++; $display("FAIL flags_halt: got halt %b rdy %b want 1/0", a_halt, a_rdy); end
    n_checks++; if (a_cfe !== 5'h01 || a_cfc !== 5'h00) begin n_errors++; $display("FAIL flags_capture: got %h/%h want 01/00", a_cfe, a_cfc); end
    drive_cycle(0, 64'd0, 5'd0, 2'd0, 1, 64'h0BAD, 5'h1F);
    n_checks++; if (a_fcnt !== 32'(m_fail) || a_pass !== 32'd0 || a_fail !== 1'b0 || a_und !== 1'b0) begin n_errors++; $display("FAIL flags_ignored: got cnt %0d pulse %b und %b want 1/0/0", a_fcnt, a_fail, a_und); end
    n_checks++; if (a_pend !== 4'(q.size())) begin n_errors++; $display("FAIL flags_pending: got %0d want %0d", a_pend, q.size()); end
  endtask

  task automatic test_underflow_clear();
    do_clear();
    drive_cycle(1, 64'h1234, 5'd0, 2'd0, 1, 64'h1234, 5'd0);
    n_checks++; if (a_und !== 1'b1 || a_halt !== 1'b1) begin n_errors++; $display("FAIL under_flag: got und %b halt %b want 1/1", a_und, a_halt); end
    n_checks++; if (a_pass !== 32'd0 || a_pend !== 4'(q.size())) begin n_errors++; $display("FAIL under_nobypass: got pass %0d pend %0d want 0/%0d", a_pass, a_pend, q.size()); end
    do_clear();
    n_checks++; if ({a_und, a_halt, a_fail} !== 3'b000 || a_rdy !== 1'b1 || a_pend !== 4'd0) begin n_errors++; $display("FAIL clear_state: got und/halt/fail %b rdy %b pend %0d", {a_und, a_halt, a_fail}, a_rdy, a_pend); end
    n_checks++; if (a_pass !== 32'd0 || a_fcnt !== 32'd0 || a_ccalc !== 64'd0) begin n_errors++; $display("FAIL clear_stats: got %0d/%0d cap %h want 0", a_pass, a_fcnt, a_ccalc); end
    drive_cycle(1, 64'h55, 5'd0, 2'd0, 0, 64'd0, 5'd0);
    drive_cycle(1, 64'h66, 5'd0, 2'd0, 0, 64'd0, 5'd0);
    do_clear();
    drive_cycle(0, 64'd0, 5'd0, 2'd0, 1, 64'h55, 5'd0);
    n_checks++; if (a_und !== 1'b1 || a_pass !== 32'd0) begin n_errors++; $display("FAIL clear_discard: got und %b pass %0d want 1/0", a_und, a_pass); end
  endtask

  task automatic test_no_stop();
    do_clear();
    drive_cycle(1, 64'h4000_0000, 5'h00, 2'd0, 0, 64'd0, 5'd0);
    drive_cycle(1, 64'h4040_0000, 5'h00, 2'd0, 0, 64'd0, 5'd0);
    drive_cycle(1, 64'h4080_0000, 5'h02, 2'd0, 0, 64'd0, 5'd0);
    drive_cycle(0, 64'd0, 5'd0, 2'd0, 1, 64'h4000_0001, 5'h00);
    drive_cycle(0, 64'd0, 5'd0, 2'd0, 1, 64'h4040_0000, 5'h00);
    drive_cycle(0, 64'd0, 5'd0, 2'd0, 1, 64'h4080_0000, 5'h00);
    n_checks++; if (b_fail !== 1'b1 || b_halt !== 1'b0) begin n_errors++; $display("FAIL nostop_pulse: got fail %b halt %b want 1/0", b_fail, b_halt); end
    n_checks++; if (b_fcnt !== 32'd2 || b_pass !== 32'd1 || b_pend !== 4'd0) begin n_errors++; $display("FAIL nostop_counts: got %0d/%0d pend %0d want 2/1/0", b_fcnt, b_pass, b_pend); end
    n_checks++; if (b_cexp !== 64'h4000_0000 || b_ccalc !== 64'h4000_0001) begin n_errors++; $display("FAIL nostop_capture: got %h/%h want 40000000/40000001", b_cexp, b_ccalc); end
    n_checks++; if (b_cfe !== 5'h00 || b_cfc !== 5'h00) begin n_errors++; $display("FAIL nostop_cap_flags: got %h/%h want 00/00", b_cfe, b_cfc); end
    n_checks++; if (a_halt !== 1'b1 || a_fcnt !== 32'(m_fail)) begin n_errors++; $display("FAIL stop_vs_nostop: got halt %b cnt %0d want 1/%0d", a_halt, a_fcnt, m_fail); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; exp_valid = 1'b0; res_valid = 1'b0;
    exp_result = '0; exp_flags = '0; exp_fmt = '0; res_result = '0; res_flags = '0;
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_nan();
    test_flags_halt();
    test_underflow_clear();
    test_no_stop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fp_check_scoreboard.md
# fp_check_scoreboard

In-order result scoreboard for the floating-point unit. It queues expected results and flags from the vector source, and pairs each DUT completion (`ready` pulse from `fp_unit`) with the oldest queued expectation. The two are compared with optional canonical-NaN masking, and pass/fail statistics plus the first failing record are kept. It replaces the fixed 3-register delay line with a parametrised FIFO, so DUT latency may vary per operation (div/sqrt).

## Interface
Parameters:
- `DEPTH`, 8: expected-entry FIFO depth, power of two, ≥2.
- `CNT_W`, 32: width of pass/fail counters.
- `STOP_ON_FAIL`, 1: 1 = enter HALT on first mismatch; 0 = keep checking.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `clear`  in  1  synchronous soft clear; same effect as `reset`.
- `exp_valid`  in  1  expected entry offered.
- `exp_ready`  out  1  FIFO can accept.
- `exp_result`  in  64  reference result.
- `exp_flags`  in  5  reference flags (NV,DZ,OF,UF,NX).
- `exp_fmt`  in  2  0 = fp32, 1 = fp64.
- `res_valid`  in  1  DUT completion (`fp_exe_o.ready`).
- `res_result`  in  64  DUT result.
- `res_flags`  in  5  DUT flags.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `pass_count`, `fail_count`  out  CNT_W  saturating counters.
- `fail`  out  1  one-cycle pulse per mismatch.
- `halted`  out  1  state == HALT.
- `underflow`  out  1  sticky: completion with empty FIFO.
- `cap_exp`, `cap_calc`  out  64  first-failure results.
- `cap_flags_exp`, `cap_flags_calc`  out  5  first-failure flags.

## Operation
- States: RUN, HALT.
  - RUN → HALT on a mismatch when `STOP_ON_FAIL`=1, or on underflow.
  - HALT → RUN only on `reset`/`clear`.
  - In HALT, `exp_ready`=0 and `res_valid` is ignored; counters and capture are frozen.
- Push: `exp_valid & exp_ready` writes {result, flags, fmt} at the write pointer.
- `exp_ready` = RUN and `pending < DEPTH`. There is no same-cycle pass-through of a pop into a full FIFO.
- Pop: `res_valid` in RUN with `pending>0` compares against the FIFO head and advances the read pointer.
- Simultaneous push and pop: both occur, and `pending` is unchanged.
- Empty FIFO with `res_valid`:
  - An entry pushed in the same cycle is not visible (no bypass).
  - `underflow` is set and the block enters HALT.
- Pointers are `$clog2(DEPTH)+1` bits and wrap modulo 2·DEPTH. Full/empty are decided by pointer MSB comparison.
- Compare: `rdiff = exp ^ calc`, `fdiff = exp_flags ^ res_flags`. The pair matches when `rdiff`=0 after masking and `fdiff`=0.
- Pass increments `pass_count`; mismatch increments `fail_count` and pulses `fail`. Both counters saturate at all-ones.
- Capture registers load on the first mismatch only (while `fail_count`==0). They hold until reset/clear.

## Timing
- All outputs are registered.
- Reset/clear values:
  - state RUN, `pending`=0, counters 0, `fail`=0, `underflow`=0, capture registers 0.
  - `exp_ready`=1 the cycle after reset deasserts.
- Push latency: an entry pushed in cycle N is comparable from cycle N+1.
- Compare latency: `res_valid` in cycle N updates counters, `fail`, capture, `halted` and `pending` at edge N+1.
- Back-to-back `res_valid` is supported at one compare per cycle.
- Reset or clear mid-operation discards all queued entries with no compare.

## Configuration
- `FP_CHECK_NAN_MASK_EN` defined: canonical NaN results are masked.
  - If `exp_fmt`=0 and `res_result`==64'h000000007FC00000, clear `rdiff[21:0]` and `rdiff[63:31]`.
  - If `exp_fmt`=1 and `res_result`==64'h7FF8000000000000, clear `rdiff[50:0]` and `rdiff[63]`.
  - Flags are always compared.
- Undefined: exact 64-bit result compare, with no masking logic present.

## Test plan
- Push {0x3F800000, flags 0, fp32} ×3, then 3 matching `res_valid` on consecutive cycles → `pass_count`=3, `fail`=0, `pending`=0.
- Push 8 entries with DEPTH=8 while `exp_valid` stays high → `exp_ready`=0 at `pending`=8. A pop and an offered push in the same cycle → `pending` goes to 7 and the push is refused that cycle.
- Expected 0x7FC00001 fp32, DUT 0x7FC00000 → pass with the macro defined; with the macro undefined, `fail` pulses and `cap_calc`=0x7FC00000.
- Expected flags 0x01, DUT flags 0x00 with equal results, STOP_ON_FAIL=1 → `fail_count`=1, `halted`=1 next cycle, and a later `res_valid` is ignored.
- `res_valid` with empty FIFO and a same-cycle push → `underflow`=1, `halted`=1. Then `clear` → all outputs return to reset values.
- STOP_ON_FAIL=0 with two mismatches → `fail_count`=2 and capture holds the first mismatch's values.
